// File: rtl/radar_pkg.sv
// radar_pkg: shared types and constants for the radar display datapath
package radar_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam int DIST_W = 11;
  localparam int DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ZERO = 7'b1111110;
  // Leading-zero blanking: a digit is dark when it and every digit above it are zero
  function automatic logic [3:0] blank_mask(input logic [15:0] v);
    return {v[15:12] == 4'd0, v[15:8] == 8'd0, v[15:4] == 12'd0, 1'b0};
  endfunction
endpackage

// File: rtl/distance_display_mux_if.sv
// distance_display_mux_if: distance input and multiplexed display outputs
interface distance_display_mux_if;
  import radar_pkg::*;
  logic dist_valid;
  logic [DIST_W-1:0] dist_cm;
  logic busy;
  logic [15:0] bcd;
  logic [6:0] seg_out;
  logic [3:0] dig_en;
  modport master(output dist_valid, dist_cm, input busy, bcd, seg_out, dig_en);
  modport slave(input dist_valid, dist_cm, output busy, bcd, seg_out, dig_en);
endinterface

// File: rtl/seg7.sv
// seg7: BCD digit to active-high {a..g} segment pattern
import radar_pkg::*;
module seg7 (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_ZERO;
    case (d)
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = SEG_ZERO;
    endcase
  end
endmodule

// File: rtl/distance_display_mux.sv
// distance_display_mux: sequential binary-to-BCD conversion feeding a scanned 4-digit 7-segment display
import radar_pkg::*;
module distance_display_mux #(
  parameter int CLK_HZ = 27000000,
  parameter int SCAN_DIV = 27000
) (
  input logic clk,
  input logic rst,
  distance_display_mux_if.slave io
);
  localparam int CW = $clog2(SCAN_DIV);
  if (SCAN_DIV < 2 || SCAN_DIV > CLK_HZ) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2 and no larger than CLK_HZ");
  end
  state_t state, state_nxt;
  logic [DIST_W-1:0] sh;
  logic [15:0] acc, acc_adj, bcd;
  logic [3:0] it, blank, dig_en;
  logic busy;
  logic [CW-1:0] ref_cnt;
  logic [1:0] idx, idx_nxt;
  logic wrap;
  logic [6:0] glyph, seg_out;
  assign io.busy = busy;
  assign io.bcd = bcd;
  assign io.seg_out = seg_out;
  assign io.dig_en = dig_en;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (io.dist_valid ? CONV : IDLE)
              : state == CONV ? (it == 4'(DIST_W - 1) ? LOAD : CONV)
              : IDLE;
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++)
      acc_adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
      acc <= '0;
      it <= '0;
      busy <= 1'b0;
      bcd <= '0;
      blank <= 4'b1110;
    end else begin
      busy <= state_nxt != IDLE;
      if (state == IDLE && io.dist_valid) begin
        sh <= io.dist_cm;
        acc <= '0;
        it <= '0;
      end else if (state == CONV) begin
        {acc, sh} <= {acc_adj, sh} << 1;
        it <= it + 4'd1;
      end else if (state == LOAD) begin
        bcd <= acc;
        blank <= blank_mask(acc);
      end
    end
  end
  // Segments are computed from the slot about to be shown so they switch with dig_en
  assign wrap = ref_cnt == CW'(SCAN_DIV - 1);
  assign idx_nxt = wrap ? idx + 2'd1 : idx;
  seg7 u_seg7 (.d(bcd[{idx_nxt, 2'b00} +: 4]), .seg(glyph));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx <= '0;
      dig_en <= 4'b0001;
      seg_out <= SEG_ZERO;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + CW'(1);
      idx <= idx_nxt;
      dig_en <= 4'(1) << idx_nxt;
      seg_out <= blank[idx_nxt] ? SEG_BLANK : glyph;
    end
  end
endmodule

// File: doc/distance_display_mux.md
# distance_display_mux

Downstream consumer of the ultrasonic ranging path. It accepts a binary distance in centimetres with a one-cycle valid strobe and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a single common 7-segment bus with one-hot digit enables and leading-zero blanking. It replaces the single-digit display stage at the end of the radar datapath.

## Interface
- `CLK_HZ`, default 27000000: system clock frequency. Documentation only.
- `SCAN_DIV`, default 27000: clock cycles per digit slot, giving 1 kHz per digit. Must be ≥ 2.
- `clk` in 1: system clock, rising-edge. One clock domain only.
- `rst` in 1: reset, asynchronous and active-high.
- `dist_valid` in 1: single-cycle strobe meaning `dist_cm` is valid.
- `dist_cm` in 11: distance in cm, unsigned, range 0..2047.
- `busy` out 1: high while a conversion is in progress.
- `bcd` out 16: last converted value as four nibbles, `{thousands, hundreds, tens, units}`.
- `seg_out` out 7: segments `{a,b,c,d,e,f,g}`, active-high. The glyph for 0 is 7'b1111110.
- `dig_en` out 4: one-hot active-high digit enable. Bit 0 is units, bit 3 is thousands.

## Operation
- FSM states:
  - IDLE: accepts `dist_valid`.
  - CONV: 11 shift/add-3 iterations, one per cycle.
  - LOAD: commits the result to `bcd` and the display register.
- IDLE to CONV: on `dist_valid`=1. `dist_cm` is captured into an 11-bit shift register and a 16-bit BCD accumulator is cleared.
- CONV, each cycle:
  - Each accumulator nibble ≥ 5 gets +3.
  - Then `{acc, sh}` shifts left by 1.
  - An iteration counter runs 0..10. After iteration 10 the FSM moves to LOAD.
- LOAD:
  - `bcd` ← accumulator.
  - Blank mask recomputed: thousands blank if 0; hundreds blank if thousands and hundreds are both 0; tens blank if the upper three digits are all 0. Units is never blank.
  - Returns to IDLE.
- `dist_valid` while `busy`: ignored. The sample is dropped and the conversion in flight is unaffected.
- Scan path runs independently of the FSM:
  - Refresh counter counts 0..SCAN_DIV-1.
  - On wrap, the 2-bit digit index increments 0→1→2→3→0.
  - `dig_en` = 1 << index.
  - `seg_out` = decode of the selected nibble, or 7'b0000000 if that digit is blanked.
- A display update in LOAD takes effect in the current scan slot on the next cycle. The scan phase is not reset.
- Nibbles are always 0..9 by construction. The decoder default (non-BCD) yields the glyph for 0.

## Timing
- All outputs are registered.
- Reset values:
  - `busy`=0, `bcd`=16'h0000.
  - Blank mask = upper three digits blanked.
  - Refresh counter = 0, index = 0.
  - `dig_en`=4'b0001, `seg_out`=7'b1111110.
- Latency, with `dist_valid` sampled high at edge N:
  - `busy`=1 from N+1 through N+12.
  - CONV iterations occupy edges N+1..N+11.
  - LOAD at edge N+12 updates `bcd` and the display register.
  - `busy`=0 after edge N+13.
  - A new strobe is accepted at edge N+13 at the earliest. Maximum throughput is one sample per 13 cycles.
- Scan: each digit is held for exactly SCAN_DIV cycles. `seg_out` and `dig_en` change on the same edge, so there is no mismatched cycle.
- Reset asserted mid-conversion: the FSM goes to IDLE immediately and the partial result is discarded. `bcd` returns to 0.

## Structure
- Shared package `radar_pkg`:
  - FSM state enum (IDLE, CONV, LOAD).
  - `DIST_W`=11, `DIGITS`=4.
  - `SEG_BLANK`=7'b0000000, `SEG_ZERO`=7'b1111110.
- Sub-module: reuse the existing combinational `seg7` decoder (4-bit in, 7-bit out) for the selected nibble.
- The double-dabble engine lives inline in this module. No separate module.

## Test plan
Bench overrides SCAN_DIV=4.
- Reset, then idle for 40 cycles → `busy`=0 and `bcd`=0000. `dig_en` cycles 0001,0010,0100,1000 every 4 cycles. `seg_out`=1111110 on the units slot and 0000000 on the others.
- `dist_cm`=1234 strobed at edge N → `busy` high N+1..N+12, `bcd`=16'h1234 after N+12. Scan shows 1111110 is not used anywhere; segments per slot: units 0110011, tens 1111001, hundreds 1101101, thousands 0110000.
- `dist_cm`=7 → `bcd`=0007. Thousands, hundreds and tens slots are 0000000; units is 1110000.
- `dist_cm`=2047 then `dist_cm`=0, with the second strobe at N+5 → second strobe dropped, `bcd`=16'h2047. A strobe at N+13 is accepted → `bcd`=0000, and only the units slot is lit.
- `dist_cm`=105 → `bcd`=0105, thousands blanked, the interior zero is shown: tens slot 1111110.
- `rst` pulsed at N+6 of a conversion of 999 → all outputs return to their reset values asynchronously. `bcd` stays 0000 after release until a new strobe.
